// File: rtl/qea_host_pkg.sv
// Shared types and helpers for the QEA host sequencer: FSM encoding,
// the fixed-point 1.0 constant and the state-RAM row count.
package qea_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_CTX,
    ST_INIT_STATE,
    ST_START,
    ST_RUN,
    ST_READ,
    ST_DONE
  } seq_state_e;

  function automatic logic [63:0] fxp_one(input int frac_bits);
    return 64'd1 << frac_bits;
  endfunction

  // Rows of PE_NUM amplitudes needed for a 2**qbit_num state vector.
  function automatic logic [31:0] row_count(input int qbit_num, input int pe_num_width);
    return 32'd1 << (qbit_num - pe_num_width);
  endfunction

endpackage

// File: rtl/qea_rd_fifo2.sv
// Two-entry synchronous FIFO with occupancy output for the readout path.
// Push into a full FIFO is dropped unless a pop happens in the same cycle.
module qea_rd_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       cnt_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && (cnt_q != 2'd0);
  assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: ;
      endcase
    end
  end

  assign pop_dat_o = mem_q[rd_ptr_q];
  assign count_o   = cnt_q;

endmodule

// File: rtl/qea_host_sequencer.sv
// Loads QEA context, zero-initialises the state RAM, starts and times the QEA,
// then streams the state vector out; readout never overruns its 2-entry FIFO.
module qea_host_sequencer
  import qea_host_pkg::*;
#(
  parameter int PE_NUM_WIDTH            = 2,
  parameter int PE_NUM                  = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int STATE_DATA_WIDTH        = 2 * DATA_WIDTH,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_DATA_WIDTH = 2 * DATA_WIDTH,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int NUM_FRAC_BIT            = 30
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_run,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH:0]     i_ins_num,
  input  logic                                 s_ctx_valid,
  output logic                                 s_ctx_ready,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   s_ctx_data,
  output logic                                 o_ctx_en,
  output logic                                 o_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
  output logic                                 o_state_ena,
  output logic                                 o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout,
  output logic                                 o_qea_start,
  input  logic                                 i_qea_complete,
  output logic                                 m_out_valid,
  input  logic                                 m_out_ready,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   m_out_data,
  output logic                                 m_out_last,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_err,
  output logic [31:0]                          o_cycle_count
);

  localparam int ROW_W    = STATE_ADDR_WIDTH + 1;
  localparam int INS_W    = GATE_CONTEXT_ADDR_WIDTH + 1;
  localparam int ROW_BITS = PE_NUM * STATE_DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] ONE_FXP = DATA_WIDTH'(fxp_one(NUM_FRAC_BIT));
  localparam logic [INS_W-1:0]      MAX_INS = {1'b1, {GATE_CONTEXT_ADDR_WIDTH{1'b0}}};

  seq_state_e                   state_q, state_d;
  logic [INS_W-1:0]             ins_q, ins_d;
  logic [INS_W-1:0]             acc_q, acc_d;
  logic [ROW_W-1:0]             rows_q, rows_d;
  logic [ROW_W-1:0]             row_q, row_d;
  logic                         err_q, err_d;
  logic [31:0]                  cyc_q, cyc_d;
  logic                         ctx_wr_q;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ctx_addr_q;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx_dat_q;
  logic                         rd_inflight_q;
  logic                         rd_inflight_last_q;
  logic                         cfg_bad;
  logic                         ctx_hs;
  logic                         out_hs;
  logic                         rd_issue;
  logic                         row_is_last;
  logic [1:0]                   fifo_cnt;
  logic [ROW_BITS:0]            fifo_dout;

  assign cfg_bad = (i_ins_num == '0)
                || (i_qbit_num < MAX_QBIT_WIDTH'(PE_NUM_WIDTH))
                || (i_qbit_num > MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + PE_NUM_WIDTH))
                || (i_ins_num > MAX_INS);

  assign s_ctx_ready = (state_q == ST_LOAD_CTX) && (acc_q != ins_q);
  assign ctx_hs      = s_ctx_valid && s_ctx_ready;
  assign out_hs      = m_out_valid && m_out_ready;
  assign row_is_last = (row_q == rows_q - ROW_W'(1));

  always_comb begin
    state_d       = state_q;
    ins_d         = ins_q;
    acc_d         = acc_q;
    rows_d        = rows_q;
    row_d         = row_q;
    err_d         = err_q;
    cyc_d         = cyc_q;
    rd_issue      = 1'b0;
    o_state_ena   = 1'b0;
    o_state_wea   = 1'b0;
    o_state_addra = '0;
    o_state_dina  = '0;
    o_qea_start   = 1'b0;
    o_done        = 1'b0;
    case (state_q)
      ST_IDLE: if (i_run) begin
        ins_d   = i_ins_num;
        rows_d  = ROW_W'(row_count(int'(i_qbit_num), PE_NUM_WIDTH));
        acc_d   = '0;
        row_d   = '0;
        err_d   = cfg_bad;
        state_d = cfg_bad ? ST_DONE : ST_LOAD_CTX;
      end
      ST_LOAD_CTX: begin
        if (ctx_hs) acc_d = acc_q + INS_W'(1);
        // acc_q equals index+1 of the word being written this cycle
        if (ctx_wr_q && (acc_q == ins_q)) state_d = ST_INIT_STATE;
      end
      ST_INIT_STATE: begin
        o_state_ena   = 1'b1;
        o_state_wea   = 1'b1;
        o_state_addra = row_q[STATE_ADDR_WIDTH-1:0];
        if (row_q == '0) o_state_dina = {ONE_FXP, {(ROW_BITS - DATA_WIDTH){1'b0}}};
        if (row_is_last) begin
          row_d   = '0;
          state_d = ST_START;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end
      ST_START: begin
        o_qea_start = 1'b1;
        cyc_d       = '0;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        if (i_qea_complete) state_d = ST_READ;
        else if (cyc_q != '1) cyc_d = cyc_q + 32'd1;
      end
      ST_READ: begin
        // A row leaving this cycle frees its slot before the new read returns.
        rd_issue = (row_q != rows_q)
                && (({1'b0, fifo_cnt} + {2'b00, rd_inflight_q}) < (3'd2 + {2'b00, out_hs}));
        if (rd_issue) begin
          o_state_ena   = 1'b1;
          o_state_addra = row_q[STATE_ADDR_WIDTH-1:0];
          row_d         = row_q + ROW_W'(1);
        end
        if (out_hs && m_out_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        o_done  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= ST_IDLE;
      ins_q              <= '0;
      acc_q              <= '0;
      rows_q             <= '0;
      row_q              <= '0;
      err_q              <= 1'b0;
      cyc_q              <= '0;
      ctx_wr_q           <= 1'b0;
      ctx_addr_q         <= '0;
      ctx_dat_q          <= '0;
      rd_inflight_q      <= 1'b0;
      rd_inflight_last_q <= 1'b0;
    end else begin
      state_q            <= state_d;
      ins_q              <= ins_d;
      acc_q              <= acc_d;
      rows_q             <= rows_d;
      row_q              <= row_d;
      err_q              <= err_d;
      cyc_q              <= cyc_d;
      ctx_wr_q           <= ctx_hs;
      rd_inflight_q      <= rd_issue;
      rd_inflight_last_q <= rd_issue && row_is_last;
      if (ctx_hs) begin
        ctx_addr_q <= acc_q[GATE_CONTEXT_ADDR_WIDTH-1:0];
        ctx_dat_q  <= s_ctx_data;
      end
    end
  end

  qea_rd_fifo2 #(
    .WIDTH(ROW_BITS + 1)
  ) u_rd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (rd_inflight_q),
    .push_dat_i({rd_inflight_last_q, i_state_dout}),
    .pop_i     (out_hs),
    .pop_dat_o (fifo_dout),
    .count_o   (fifo_cnt)
  );

  assign m_out_valid   = (fifo_cnt != 2'd0);
  assign m_out_data    = fifo_dout[ROW_BITS-1:0];
  assign m_out_last    = fifo_dout[ROW_BITS];
  assign o_ctx_en      = ctx_wr_q;
  assign o_ctx_wea     = ctx_wr_q;
  assign o_ctx_addr    = ctx_addr_q;
  assign o_ctx_data    = ctx_dat_q;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_err         = err_q;
  assign o_cycle_count = cyc_q;

endmodule

// File: tb/tb_qea_host_sequencer.sv
// Directed bench for qea_host_sequencer: table of full runs plus reset corner cases.
module tb_qea_host_sequencer;

  localparam int RW = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_run = 1'b0;
  logic [5:0]    i_qbit_num = '0;
  logic [16:0]   i_ins_num = '0;
  logic          s_ctx_valid = 1'b0;
  logic          s_ctx_ready;
  logic [63:0]   s_ctx_data = '0;
  logic          o_ctx_en, o_ctx_wea;
  logic [15:0]   o_ctx_addr;
  logic [63:0]   o_ctx_data;
  logic          o_state_ena, o_state_wea;
  logic [15:0]   o_state_addra;
  logic [RW-1:0] o_state_dina;
  logic [RW-1:0] i_state_dout = '0;
  logic          o_qea_start;
  logic          i_qea_complete = 1'b0;
  logic          m_out_valid;
  logic          m_out_ready = 1'b0;
  logic [RW-1:0] m_out_data;
  logic          m_out_last;
  logic          o_busy, o_done, o_err;
  logic [31:0]   o_cycle_count;

  always #5 clk = ~clk;

  qea_host_sequencer dut (
    .clk(clk), .rst_n(rst_n), .i_run(i_run), .i_qbit_num(i_qbit_num), .i_ins_num(i_ins_num),
    .s_ctx_valid(s_ctx_valid), .s_ctx_ready(s_ctx_ready), .s_ctx_data(s_ctx_data),
    .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea), .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data),
    .o_state_ena(o_state_ena), .o_state_wea(o_state_wea), .o_state_addra(o_state_addra),
    .o_state_dina(o_state_dina), .i_state_dout(i_state_dout), .o_qea_start(o_qea_start),
    .i_qea_complete(i_qea_complete), .m_out_valid(m_out_valid), .m_out_ready(m_out_ready),
    .m_out_data(m_out_data), .m_out_last(m_out_last), .o_busy(o_busy), .o_done(o_done),
    .o_err(o_err), .o_cycle_count(o_cycle_count)
  );

  typedef struct {
    int qbit;
    int ins;
    bit ctx_rand;
    int rdy_duty;
    int cmp_dly;
    bit exp_err;
    int exp_rows;
    int exp_ctx;
    int exp_cyc;
    bit chk_tim;
  } vec_t;

  vec_t tab[9];
  int   n_chk  = 0;
  int   n_fail = 0;

  localparam logic [RW-1:0] ROW0    = {64'h40000000_00000000, 192'd0};
  localparam logic [RW-1:0] ZERO    = '0;
  localparam logic [RW-1:0] GARBAGE = {8{32'hBAD0BAD0}};

  task automatic chk(input string name, input logic [RW:0] act, input logic [RW:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ctx_word(input int i);
    logic [31:0] u;
    u = i;
    return {16'hC7C7, u[15:0], u * 32'd3 + 32'd1};
  endfunction

  function automatic logic [RW-1:0] row_pat(input int r);
    logic [31:0] u;
    u = r;
    return {u, ~u, u ^ 32'hA5A5A5A5, u + 32'd256, u * 32'd3, u << 4, u | 32'hFEED0000, 32'h5A5A5A5A};
  endfunction

  function automatic logic any_out();
    return |{s_ctx_ready, o_ctx_en, o_ctx_wea, o_ctx_addr, o_ctx_data, o_state_ena, o_state_wea,
             o_state_addra, o_state_dina, o_qea_start, m_out_valid, m_out_data, m_out_last,
             o_busy, o_done, o_err, o_cycle_count};
  endfunction

  task automatic run_case(input vec_t v);
    int ctx_sent = 0, ctx_wr = 0, st_wr = 0, starts = 0, outs = 0;
    int start_c = -1, first_st = -1, done_c = -1, prev_addr = 0;
    bit prev_rd = 0, stall = 0;
    logic [RW-1:0] stall_dat = '0;
    logic stall_last = 1'b0;
    @(negedge clk);
    i_qbit_num     = 6'(v.qbit);
    i_ins_num      = 17'(v.ins);
    i_run          = 1'b1;
    i_qea_complete = 1'b0;
    s_ctx_valid    = 1'b0;
    m_out_ready    = 1'b0;
    for (int c = 1; c <= 20000 && done_c < 0; c++) begin
      @(negedge clk);
      if (c == 1) i_run = 1'b0;
      if (c == 3 && !v.exp_err) begin
        i_run = 1'b1; i_ins_num = '0; i_qbit_num = 6'd1;
      end
      if (c == 4) i_run = 1'b0;
      i_state_dout   = prev_rd ? row_pat(prev_addr) : GARBAGE;
      s_ctx_valid    = v.ctx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      s_ctx_data     = ctx_word(ctx_sent);
      m_out_ready    = ($urandom_range(0, 99) < v.rdy_duty);
      i_qea_complete = (start_c >= 0) && (c > start_c + v.cmp_dly);
      #1;
      if (c == 1) begin
        chk("busy_after_run", o_busy, 1);
        chk("err_on_accept", o_err, v.exp_err);
      end
      if (s_ctx_valid && s_ctx_ready) ctx_sent++;
      if (o_ctx_en) begin
        chk("ctx_wea", o_ctx_wea, 1);
        chk("ctx_addr", o_ctx_addr, ctx_wr);
        chk("ctx_data", o_ctx_data, ctx_word(ctx_wr));
        ctx_wr++;
      end
      if (o_state_ena && o_state_wea) begin
        if (first_st < 0) first_st = c;
        chk("st_addr", o_state_addra, st_wr);
        chk("st_data", o_state_dina, (st_wr == 0) ? ROW0 : ZERO);
        st_wr++;
      end
      prev_rd   = o_state_ena && !o_state_wea;
      prev_addr = int'(o_state_addra);
      if (o_qea_start) begin
        starts++;
        start_c = c;
      end
      if (stall) begin
        chk("stall_valid", m_out_valid, 1);
        chk("stall_data", m_out_data, stall_dat);
        chk("stall_last", m_out_last, stall_last);
      end
      stall      = m_out_valid && !m_out_ready;
      stall_dat  = m_out_data;
      stall_last = m_out_last;
      if (m_out_valid && m_out_ready) begin
        chk("out_data", m_out_data, row_pat(outs));
        chk("out_last", m_out_last, outs == v.exp_rows - 1);
        outs++;
      end
      if (o_done) done_c = c;
    end
    chk("done_seen", done_c >= 0, 1);
    chk("err_at_done", o_err, v.exp_err);
    chk("ctx_writes", ctx_wr, v.exp_ctx);
    chk("ctx_accepted", ctx_sent, v.exp_ctx);
    chk("state_writes", st_wr, v.exp_rows);
    chk("rows_out", outs, v.exp_rows);
    chk("start_pulses", starts, v.exp_err ? 0 : 1);
    if (v.exp_err) chk("err_done_cycle", done_c, 1);
    else chk("cycle_count", o_cycle_count, v.exp_cyc);
    if (v.chk_tim) begin
      chk("load_ctx_len", first_st, v.ins + 2);
      chk("init_len", start_c, v.ins + 2 + v.exp_rows);
      chk("read_len", done_c, start_c + v.cmp_dly + 4 + v.exp_rows);
    end
    @(negedge clk);
    #1;
    chk("idle_after_done", o_busy, 0);
    chk("done_single", o_done, 0);
  endtask

  initial begin
    //         qbit  ins  rnd duty dly   err rows ctx  cyc  tim
    tab[0] = '{11,   153, 0,  100, 1000, 0,  512, 153, 1000, 1};
    tab[1] = '{4,    10,  1,  100, 0,    0,  4,   10,  0,    0};
    tab[2] = '{8,    20,  0,  30,  5,    0,  64,  20,  5,    0};
    tab[3] = '{6,    0,   0,  100, 0,    1,  0,   0,   0,    0};
    tab[4] = '{1,    5,   0,  100, 0,    1,  0,   0,   0,    0};
    tab[5] = '{2,    1,   0,  100, 3,    0,  1,   1,   3,    1};
    tab[6] = '{19,   5,   0,  100, 0,    1,  0,   0,   0,    0};
    tab[7] = '{5,    65537, 0, 100, 0,   1,  0,   0,   0,    0};
    tab[8] = '{9,    40,  1,  30,  7,    0,  128, 40,  7,    0};

    #12;
    chk("reset_outputs_zero", any_out(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_busy", o_busy, 0);

    foreach (tab[i]) run_case(tab[i]);

    begin
      bit seen = 0;
      @(negedge clk);
      i_qbit_num = 6'd11; i_ins_num = 17'd3; i_run = 1'b1;
      s_ctx_valid = 1'b1; m_out_ready = 1'b1; i_qea_complete = 1'b0;
      @(negedge clk);
      i_run = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
        @(negedge clk);
        #1;
        if (o_state_wea) seen = 1;
      end
      chk("init_reached", seen, 1);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_zero", any_out(), 0);
      chk("async_reset_busy", o_busy, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
    end

    run_case(tab[2]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
